// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo_wr_arbiter write-port arbiter.
`timescale 1ns/1ps
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int BEAT_CNT_W = 8;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Rotating priority encoder: first set request at or above rr_ptr, wrapping at NUM_REQ.
`timescale 1ns/1ps
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan upward from rr_ptr; rr_ptr may exceed NUM_REQ-1 only by less than 2*NUM_REQ.
  always_comb begin
    int raw;
    int pos;
    logic [IDX_W-1:0] sel;
    logic hit;
    valid = 1'b0;
    idx   = '0;
    raw   = 0;
    pos   = 0;
    sel   = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      raw   = int'(rr_ptr) + k;
      pos   = (raw >= NUM_REQ) ? raw - NUM_REQ : raw;
      pos   = (pos >= NUM_REQ) ? pos - NUM_REQ : pos;
      sel   = IDX_W'(pos);
      hit   = !valid && req[sel];
      idx   = hit ? sel : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one fifo_unit write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to build the saturating full-stall counter behind stall_cnt.
`timescale 1ns/1ps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
  output logic [idx_width(NUM_REQ)-1:0] owner,
  output logic [15:0]                   stall_cnt
);

  localparam int                    IDX_W       = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_CNT_W-1:0] BURST_LEN   = BEAT_CNT_W'(MAX_BURST);
  localparam bit                    SINGLE_BEAT = (MAX_BURST == 1);

  arb_state_e              st_r;
  arb_state_e              st_nxt_s;
  logic [IDX_W-1:0]        owner_r;
  logic [IDX_W-1:0]        owner_nxt_s;
  logic [BEAT_CNT_W-1:0]   beat_cnt_r;
  logic [BEAT_CNT_W-1:0]   beat_cnt_nxt_s;
  logic [IDX_W-1:0]        rr_ptr_r;
  logic [IDX_W-1:0]        rr_ptr_nxt_s;
  logic [NUM_REQ-1:0]      gnt_s;
  logic                    pick_valid_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic [BEAT_CNT_W-1:0]   beat_inc_s;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  fifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .valid  (pick_valid_s),
    .idx    (pick_idx_s)
  );

  assign beat_inc_s = beat_cnt_r + BEAT_CNT_W'(1);

  // Arbitration FSM: grant decision and next-state, all from registered state.
  always_comb begin
    gnt_s          = '0;
    st_nxt_s       = st_r;
    owner_nxt_s    = owner_r;
    beat_cnt_nxt_s = beat_cnt_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    case (st_r)
      ARB_IDLE: begin
        if (pick_valid_s && !fifo_full) begin
          gnt_s[pick_idx_s] = 1'b1;
          owner_nxt_s       = pick_idx_s;
          beat_cnt_nxt_s    = BEAT_CNT_W'(1);
          if (SINGLE_BEAT) begin
            rr_ptr_nxt_s = wrap_inc(pick_idx_s);
          end else begin
            st_nxt_s = ARB_BURST;
          end
        end else begin
          st_nxt_s = ARB_IDLE;
        end
      end
      ARB_BURST: begin
        if (req[owner_r]) begin
          if (!fifo_full) begin
            gnt_s[owner_r] = 1'b1;
            beat_cnt_nxt_s = beat_inc_s;
            if (beat_inc_s == BURST_LEN) begin
              st_nxt_s     = ARB_IDLE;
              rr_ptr_nxt_s = wrap_inc(owner_r);
            end else begin
              st_nxt_s = ARB_BURST;
            end
          end else begin
            st_nxt_s = ARB_BURST;
          end
        end else begin
          // Owner let go: spend one bubble cycle re-arbitrating from the next producer.
          st_nxt_s     = ARB_IDLE;
          rr_ptr_nxt_s = wrap_inc(owner_r);
        end
      end
      default: begin
        st_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Grant is forced low while reset is held so no beat slips through asynchronously.
  assign gnt     = reset_n ? gnt_s : '0;
  assign fifo_wr = |gnt;
  assign owner   = owner_r;

  // One-hot AND-OR data mux; zero when nobody is granted.
  always_comb begin
    fifo_w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fifo_w_data = fifo_w_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[i]}});
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_r       <= ARB_IDLE;
      owner_r    <= '0;
      beat_cnt_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      st_r       <= st_nxt_s;
      owner_r    <= owner_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt_r;

  // Count cycles where someone wants the port but the FIFO is full; saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 16'd0;
    end else if ((|req) && fifo_full && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: two instances (4 producers/burst 4, 5 producers/burst 2) against a rule-level model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    req;
  logic [5*DW-1:0] req_data;
  logic          full0, full1;
  logic [3:0]    gnt0;
  logic [4:0]    gnt1;
  logic          wr0, wr1;
  logic [DW-1:0] wd0, wd1;
  logic [1:0]    own0;
  logic [2:0]    own1;
  logic [15:0]   sc0, sc1;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .MAX_BURST(4)) u_arb4 (
    .clk(clk), .reset_n(reset_n), .req(req[3:0]), .req_data(req_data[4*DW-1:0]),
    .gnt(gnt0), .fifo_full(full0), .fifo_wr(wr0), .fifo_w_data(wd0),
    .owner(own0), .stall_cnt(sc0)
  );

  fifo_wr_arbiter #(.NUM_REQ(5), .DATA_WIDTH(DW), .MAX_BURST(2)) u_arb5 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .gnt(gnt1), .fifo_full(full1), .fifo_wr(wr1), .fifo_w_data(wd1),
    .owner(own1), .stall_cnt(sc1)
  );

  typedef struct {
    bit busy;
    int owner;
    int beats;
    int ptr;
    int stalls;
  } arb_model_t;

  arb_model_t   mdl [2];
  int           n_req [2]     = '{4, 5};
  int           burst_max [2] = '{4, 2};
  logic [7:0]   fq0 [$];
  logic [7:0]   fq1 [$];
  logic [7:0]   log0 [$];
  logic [7:0]   log1 [$];
  logic [7:0]   exp_rot4 [8] = '{8'd8, 8'd8, 8'd8, 8'd8, 8'd2, 8'd2, 8'd2, 8'd2};
  logic [7:0]   exp_rot5 [8] = '{8'd8, 8'd8, 8'd2, 8'd2, 8'd9, 8'd9, 8'd8, 8'd8};
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_models();
    for (int id = 0; id < 2; id++) begin
      mdl[id].busy   = 1'b0;
      mdl[id].owner  = 0;
      mdl[id].beats  = 0;
      mdl[id].ptr    = 0;
      mdl[id].stalls = 0;
    end
  endtask

  // Rule-level model: returns granted producer index for this cycle (-1 if none) and advances.
  task automatic model_step(input int id, input logic [4:0] r, input bit full, output int g);
    logic [4:0] rv;
    int n;
    int c;
    n  = n_req[id];
    rv = r & 5'((1 << n) - 1);
    g  = -1;
    if (rv != 5'd0 && full) mdl[id].stalls = (mdl[id].stalls < 65535) ? mdl[id].stalls + 1 : 65535;
    if (!mdl[id].busy) begin
      if (!full) begin
        for (int k = 0; k < n; k++) begin
          c = (mdl[id].ptr + k) % n;
          if (g < 0 && rv[c]) g = c;
        end
      end
      if (g >= 0) begin
        mdl[id].owner = g;
        mdl[id].beats = 1;
        if (burst_max[id] == 1) mdl[id].ptr = (g + 1) % n;
        else mdl[id].busy = 1'b1;
      end
    end else if (rv[mdl[id].owner]) begin
      if (!full) begin
        g = mdl[id].owner;
        mdl[id].beats++;
        if (mdl[id].beats == burst_max[id]) begin
          mdl[id].busy = 1'b0;
          mdl[id].ptr  = (mdl[id].owner + 1) % n;
        end
      end
    end else begin
      mdl[id].busy = 1'b0;
      mdl[id].ptr  = (mdl[id].owner + 1) % n;
    end
  endtask

  task automatic run_cycle(input logic [4:0] r, input logic [39:0] d, input bit pop0, input bit pop1);
    int g0, g1, eo0, eo1, es0, es1, sz0, sz1;
    logic [31:0] ed0, ed1;
    logic [7:0]  tmp;
    @(negedge clk);
    req      = r;
    req_data = d;
    sz0      = fq0.size();
    sz1      = fq1.size();
    full0    = (sz0 >= DEPTH);
    full1    = (sz1 >= DEPTH);
    eo0 = mdl[0].owner;  es0 = mdl[0].stalls;
    eo1 = mdl[1].owner;  es1 = mdl[1].stalls;
`ifndef FIFO_ARB_STATS_EN
    es0 = 0;
    es1 = 0;
`endif
    model_step(0, r, full0, g0);
    model_step(1, r, full1, g1);
    ed0 = 32'd0;
    ed1 = 32'd0;
    if (g0 >= 0) ed0 = 32'(d[g0*DW +: DW]);
    if (g1 >= 0) ed1 = 32'(d[g1*DW +: DW]);
    #1;
    check_eq("gnt4",   32'(gnt0), (g0 >= 0) ? (32'd1 << g0) : 32'd0);
    check_eq("wr4",    32'(wr0),  32'(g0 >= 0));
    check_eq("data4",  32'(wd0),  ed0);
    check_eq("owner4", 32'(own0), 32'(eo0));
    check_eq("stall4", 32'(sc0),  32'(es0));
    check_eq("gnt5",   32'(gnt1), (g1 >= 0) ? (32'd1 << g1) : 32'd0);
    check_eq("wr5",    32'(wr1),  32'(g1 >= 0));
    check_eq("data5",  32'(wd1),  ed1);
    check_eq("owner5", 32'(own1), 32'(eo1));
    check_eq("stall5", 32'(sc1),  32'(es1));
    if (wr0) begin fq0.push_back(wd0); log0.push_back(wd0); end
    if (wr1) begin fq1.push_back(wd1); log1.push_back(wd1); end
    if (pop0 && sz0 > 0) tmp = fq0.pop_front();
    if (pop1 && sz1 > 0) tmp = fq1.pop_front();
  endtask

  initial begin
    logic [4:0]  r;
    logic [39:0] d;
    reset_n  = 1'b0;
    req      = 5'b11111;
    req_data = '1;
    full0    = 1'b0;
    full1    = 1'b0;
    reset_models();
    #12;
    check_eq("rst_gnt4",   32'(gnt0), 32'd0);
    check_eq("rst_wr4",    32'(wr0),  32'd0);
    check_eq("rst_data4",  32'(wd0),  32'd0);
    check_eq("rst_owner4", 32'(own0), 32'd0);
    check_eq("rst_stall4", 32'(sc0),  32'd0);
    check_eq("rst_gnt5",   32'(gnt1), 32'd0);
    check_eq("rst_wr5",    32'(wr1),  32'd0);
    @(negedge clk);
    req     = 5'd0;
    reset_n = 1'b1;

    // Single producer 1 with data 5; both instances end up mid-burst.
    repeat (7) run_cycle(5'b00010, 40'h00_00_00_05_00, 1'b0, 1'b0);
    check_eq("single_cnt4", 32'(log0.size()), 32'd7);
    check_eq("single_cnt5", 32'(log1.size()), 32'd7);
    foreach (log0[i]) check_eq("single_data4", 32'(log0[i]), 32'd5);
    foreach (log1[i]) check_eq("single_data5", 32'(log1[i]), 32'd5);

    // Asynchronous reset between edges while bursting, with the request still held.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mrst_gnt4",   32'(gnt0), 32'd0);
    check_eq("mrst_wr4",    32'(wr0),  32'd0);
    check_eq("mrst_owner4", 32'(own0), 32'd0);
    check_eq("mrst_gnt5",   32'(gnt1), 32'd0);
    check_eq("mrst_wr5",    32'(wr1),  32'd0);
    check_eq("mrst_owner5", 32'(own1), 32'd0);
    reset_models();
    @(negedge clk);
    req     = 5'd0;
    reset_n = 1'b1;

    repeat (10) run_cycle(5'd0, 40'd0, 1'b1, 1'b1);
    log0.delete();
    log1.delete();

    // Rotation with req 1011 held from rr_ptr 0.
    repeat (8) run_cycle(5'b01011, {8'h44, 8'd9, 8'h33, 8'd2, 8'd8}, 1'b0, 1'b0);
    check_eq("rot_cnt4", 32'(log0.size()), 32'd8);
    check_eq("rot_cnt5", 32'(log1.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq("rot_seq4", 32'((i < log0.size()) ? log0[i] : 8'hxx), 32'(exp_rot4[i]));
      check_eq("rot_seq5", 32'((i < log1.size()) ? log1[i] : 8'hxx), 32'(exp_rot5[i]));
    end

    repeat (10) run_cycle(5'd0, 40'd0, 1'b1, 1'b1);

    // Fill to full with producer 2, stall, pop one, resume.
    repeat (14) run_cycle(5'b00100, {$urandom, $urandom}, 1'b0, 1'b0);
    check_eq("full_lvl4", 32'(fq0.size()), 32'd8);
    check_eq("full_lvl5", 32'(fq1.size()), 32'd8);
    run_cycle(5'b00100, {$urandom, $urandom}, 1'b1, 1'b1);
    repeat (4) run_cycle(5'b00100, {$urandom, $urandom}, 1'b0, 1'b0);
    check_eq("full_lvl4b", 32'(fq0.size()), 32'd8);
    check_eq("full_lvl5b", 32'(fq1.size()), 32'd8);

    // Stall counting with producer 0 against a full FIFO.
    repeat (10) run_cycle(5'b00001, {$urandom, $urandom}, 1'b0, 1'b0);

    // Randomized traffic with random draining and request changes.
    r = 5'd0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) == 0) r = 5'($urandom_range(0, 31));
      d = {$urandom, $urandom};
      run_cycle(r, d, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
